instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch stage of the pipelined RV32 core, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and drives a single-outstanding-request instruction-memory port with variable response latency. It delivers `pc_o`/`instr_o` to IF/ID at up to one instruction per cycle, holding the instruction when ID stalls and squashing wrong-path fetches on a branch redirect.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `stall_i`  in  1  ID-stage stall from the hazard unit (same net as IF/ID `stall_i`).
- `redirect_i`  in  1  taken branch/jump resolved in ID (same net as IF/ID `flush_i`).
- `redirect_pc_i`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `imem_req_o`  out  1  one-cycle request strobe.
- `imem_addr_o`  out  32  request address, valid while `imem_req_o`=1.
- `imem_rvalid_i`  in  1  response strobe; arrives ≥1 cycle after the request, never in the same cycle.
- `imem_rdata_i`  in  32  response instruction, valid with `imem_rvalid_i`.
- `pc_o`  out  32  PC of the instruction presented.
- `instr_o`  out  32  instruction presented; `32'h0` (bubble) when `valid_o`=0.
- `valid_o`  out  1  `instr_o` is a real, correct-path instruction.

## Operation
- Registered state: FSM state, `pc_q` (PC of the in-flight or held instruction), `hold_q` (32-bit held instruction).
- Reset: state=IDLE, `pc_q`=RESET_PC, `valid_o`=0, `instr_o`=0, `pc_o`=RESET_PC, `imem_req_o`=0.
- Consumption: the presented instruction is consumed at a clock edge iff `valid_o`=1 and `stall_i`=0.
- IDLE: `imem_req_o`=1 at `pc_q`; go to WAIT.
- WAIT, with the request outstanding:
  - no `rvalid`: stay.
  - `rvalid` and `stall_i`=0: present the instruction from `imem_rdata_i`, issue the next request at `pc_q+4` in the same cycle, set `pc_q`←`pc_q+4`, stay in WAIT.
  - `rvalid` and `stall_i`=1: present the instruction, capture it into `hold_q`, go to HOLD, no request.
- HOLD: present `hold_q`. When `stall_i`=0, issue a request at `pc_q+4`, set `pc_q`←`pc_q+4`, go to WAIT.
- DROP: a wrong-path request is outstanding and `valid_o`=0. On `rvalid`, discard the data, issue a request at `pc_q` (the target), go to WAIT.
- Redirect has priority over stall and over all state. In the redirect cycle, `valid_o`=0 and `pc_q`←`redirect_pc_i & ~3`.
  - IDLE, HOLD, or WAIT with `rvalid` this cycle: issue a request at the target this cycle, go to WAIT.
  - WAIT without `rvalid`: go to DROP, no request.
  - DROP: retarget `pc_q`. If `rvalid` arrives this cycle, issue the request at the new target and go to WAIT; otherwise stay in DROP.
- `imem_req_o` and `imem_addr_o` are combinational from state, `imem_rvalid_i`, `stall_i`, and `redirect_i`. At most one request is ever outstanding.
- `pc_o`=`pc_q`. `instr_o` is muxed from `imem_rdata_i` (WAIT) or `hold_q` (HOLD) and forced to 0 when `valid_o`=0.
- PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC`+4 = `32'h0000_0000`.

## Timing
- With 1-cycle memory, a request at cycle N gives `valid_o` at N+1 and the next request at N+1: one instruction per cycle, steady state.
- With L-cycle memory: one instruction per L cycles. `valid_o`=0 in non-response WAIT cycles, so IF/ID loads a bubble.
- First instruction after reset release: request in cycle 0 (IDLE), `valid_o` no earlier than cycle 1.
- Redirect penalty: the first correct-path instruction appears no earlier than 1 cycle after the redirect. In DROP, the penalty adds the remaining wrong-path latency.
- `rst_i` mid-operation: state returns to IDLE and any outstanding response arriving afterwards is ignored. The memory model must be reset together with this block.

## Structure
- Shared core package holds:
  - state enum {IDLE, WAIT, HOLD, DROP}
  - `BUBBLE_INSTR` = `32'h0`
  - `PC_STEP` = 4
  - `XLEN` = 32
- Single module, no sub-module. The hold register and PC incrementer are too small to split out.

## Test plan
- Reset with RESET_PC=`32'h100`, 1-cycle memory, no stall → requests at 0x100, 0x104, 0x108 in consecutive cycles; `valid_o`=1 every cycle from cycle 1 with matching `pc_o`.
- 3-cycle memory → `valid_o` pulses one cycle in every three, `instr_o`=0 in between, addresses increase by 4.
- `stall_i` held for 2 cycles while the instruction at 0x104 is presented → `instr_o`/`pc_o` stable at 0x104 for all three cycles, no request issued; request at 0x108 in the cycle `stall_i` drops.
- Redirect to `32'h2002` while a 3-cycle request is outstanding → state DROP; the wrong response is discarded (`valid_o`=0); the next request is at 0x2000.
- Redirect and stall in the same cycle while in HOLD → `valid_o`=0 and a request at the target issued in that cycle; the held instruction is never consumed.
- `pc_q`=`32'hFFFF_FFFC` consumed → next request at `32'h0000_0000`.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions for the instruction-fetch stage.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // Word-align an address by clearing its two low bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and drives a single-outstanding
// instruction-memory port, presenting one instruction per cycle to IF/ID.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_hold;
    logic [XLEN-1:0] w_hold_next;

    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_valid;
    logic [XLEN-1:0] w_instr;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_target;

    assign w_pc_inc = r_pc + XLEN'(PC_STEP);
    assign w_target = align_pc(redirect_pc_i);

    // State, fetch PC and held-instruction registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_hold  <= BUBBLE_INSTR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_hold  <= w_hold_next;
        end
    end

    // Next-state, request and presentation logic; redirect overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_hold_next  = r_hold;
        w_req        = 1'b0;
        w_addr       = r_pc;
        w_valid      = 1'b0;
        w_instr      = BUBBLE_INSTR;

        if (redirect_i) begin
            w_pc_next = w_target;
            case (r_state)
                IDLE, HOLD: begin
                    w_req        = 1'b1;
                    w_addr       = w_target;
                    w_state_next = WAIT;
                end
                WAIT, DROP: begin
                    // The port frees up only when the pending response returns.
                    if (imem_rvalid_i) begin
                        w_req        = 1'b1;
                        w_addr       = w_target;
                        w_state_next = WAIT;
                    end else begin
                        w_state_next = DROP;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    w_req        = 1'b1;
                    w_addr       = r_pc;
                    w_state_next = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        w_valid = 1'b1;
                        w_instr = imem_rdata_i;
                        if (!stall_i) begin
                            w_req     = 1'b1;
                            w_addr    = w_pc_inc;
                            w_pc_next = w_pc_inc;
                        end else begin
                            w_hold_next  = imem_rdata_i;
                            w_state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    w_valid = 1'b1;
                    w_instr = r_hold;
                    if (!stall_i) begin
                        w_req        = 1'b1;
                        w_addr       = w_pc_inc;
                        w_pc_next    = w_pc_inc;
                        w_state_next = WAIT;
                    end
                end
                DROP: begin
                    // Wrong-path data is discarded; refetch at the stored target.
                    if (imem_rvalid_i) begin
                        w_req        = 1'b1;
                        w_addr       = r_pc;
                        w_state_next = WAIT;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Outputs are quiet while reset is held so the port sees no stray request.
    assign imem_req_o  = w_req & ~rst_i;
    assign imem_addr_o = w_addr;
    assign valid_o     = w_valid & ~rst_i;
    assign instr_o     = valid_o ? w_instr : BUBBLE_INSTR;
    assign pc_o        = rst_i ? RESET_PC : r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    // Memory contents: a fixed nonzero-ish pattern per address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model and logs, owned by the stimulus process.
    int unsigned  lat = 1;
    logic         mem_pend = 1'b0;
    logic [31:0]  mem_addr = 32'h0;
    int unsigned  mem_cnt = 0;
    logic         last_req = 1'b0;
    logic [31:0]  last_addr = 32'h0;
    logic [31:0]  req_log[$];
    logic [31:0]  pc_log[$];

    // One clock cycle of stimulus plus memory bookkeeping.
    task automatic cyc(input logic rst, input logic st, input logic rd, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_rvalid_i) mem_pend = 1'b0;
            if (last_req) begin
                mem_pend = 1'b1;
                mem_addr = last_addr;
                mem_cnt  = lat - 1;
            end else if (mem_pend && mem_cnt != 0) begin
                mem_cnt--;
            end
        end
        rst_i         = rst;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        imem_rvalid_i = !rst && mem_pend && (mem_cnt == 0);
        imem_rdata_i  = imem_rvalid_i ? instr_of(mem_addr) : 32'($urandom());
        @(negedge clk);
        #1;
        last_req  = imem_req_o;
        last_addr = imem_addr_o;
        if (imem_req_o) req_log.push_back(imem_addr_o);
        if (valid_o)    pc_log.push_back(pc_o);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        req_log.delete();
        pc_log.delete();
    endtask

    // Reference model: next correct-path PC, held instruction, outstanding request.
    logic [31:0] m_pc     = RST_PC;
    logic        m_held   = 1'b0;
    logic        m_out    = 1'b0;
    logic        m_out_ok = 1'b0;

    // Compare process: every cycle, derive what the outputs must be and check them.
    always @(negedge clk) begin
        logic        e_valid, e_req, consumed, port_free, arrival_ok;
        logic [31:0] e_addr, tgt;
        n_vec++;
        if (rst_i) begin
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_req",   32'(imem_req_o), 32'd0);
            chk("rst_instr", instr_o, 32'h0);
            chk("rst_pc",    pc_o, RST_PC);
            m_pc     = RST_PC;
            m_held   = 1'b0;
            m_out    = 1'b0;
            m_out_ok = 1'b0;
        end else begin
            tgt        = {redirect_pc_i[31:2], 2'b00};
            arrival_ok = imem_rvalid_i && m_out_ok;
            e_valid    = !redirect_i && (m_held || arrival_ok);
            consumed   = e_valid && !stall_i;
            port_free  = !m_out || imem_rvalid_i;
            e_req      = port_free && !(e_valid && stall_i);
            e_addr     = redirect_i ? tgt : (consumed ? m_pc + 32'd4 : m_pc);

            chk("valid", 32'(valid_o), 32'(e_valid));
            if (e_valid) begin
                chk("pc", pc_o, m_pc);
                chk("instr", instr_o, instr_of(m_pc));
            end else begin
                chk("bubble", instr_o, 32'h0);
            end
            chk("req", 32'(imem_req_o), 32'(e_req));
            if (e_req && imem_req_o) chk("addr", imem_addr_o, e_addr);

            if (redirect_i)    m_pc = tgt;
            else if (consumed) m_pc = m_pc + 32'd4;
            m_held = e_valid && stall_i;
            if (e_req) begin
                m_out    = 1'b1;
                m_out_ok = 1'b1;
            end else if (imem_rvalid_i) begin
                m_out    = 1'b0;
                m_out_ok = 1'b0;
            end else if (redirect_i) begin
                m_out_ok = 1'b0;
            end
        end
    end

    initial begin
        // Stall while 0x104 is presented, 1-cycle memory.
        lat = 1;
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_noreq_cnt", 32'(req_log.size()), 32'd2);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("seq_nreq", 32'(req_log.size()), 32'd3);
        chk("seq_req0", req_log[0], 32'h0000_0100);
        chk("seq_req1", req_log[1], 32'h0000_0104);
        chk("seq_req2", req_log[2], 32'h0000_0108);
        chk("seq_nvalid", 32'(pc_log.size()), 32'd4);
        chk("seq_pc0", pc_log[0], 32'h0000_0100);
        chk("stall_pc1", pc_log[1], 32'h0000_0104);
        chk("stall_pc3", pc_log[3], 32'h0000_0104);

        // Redirect to 0x2002 with a 3-cycle request outstanding.
        lat = 3;
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_2002);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("drop_nreq", 32'(req_log.size()), 32'd2);
        chk("drop_req1", req_log[1], 32'h0000_2000);
        chk("drop_nvalid", 32'(pc_log.size()), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("drop_nvalid2", 32'(pc_log.size()), 32'd1);
        chk("drop_pc", pc_log[0], 32'h0000_2000);

        // Redirect together with stall while holding.
        lat = 1;
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("hold_rd_req1", req_log[1], 32'h0000_0300);
        chk("hold_rd_nvalid", 32'(pc_log.size()), 32'd2);
        chk("hold_rd_pc1", pc_log[1], 32'h0000_0300);

        // PC wraps from 0xFFFF_FFFC to 0.
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_req2", req_log[2], 32'h0000_0000);
        chk("wrap_pc0", pc_log[0], 32'hFFFF_FFFC);

        // Randomized traffic across latencies with occasional mid-run reset.
        for (int ep = 0; ep < 8; ep++) begin
            lat = 32'(ep % 4) + 1;
            do_reset();
            for (int i = 0; i < 400; i++) begin
                logic        r_rst, r_st, r_rd;
                logic [31:0] r_tgt;
                r_rst = ($urandom_range(0, 199) == 0);
                r_st  = ($urandom_range(0, 99) < 30);
                r_rd  = ($urandom_range(0, 99) < 10);
                r_tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom());
                cyc(r_rst, r_st, r_rd, r_tgt);
            end
        end

        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
